mc_ctrl_unit: RTL and testbench
===============================

Name: mc_ctrl_unit

Overview:
Multi-cycle MIPS control unit: Moore FSM that sequences fetch, decode, execute, memory and write-back. Drives every control input of the multi-cycle datapath (IorD, IRWrite, RegDst, RegWrite, MemtoReg, ALUSrcA/B, PCSource, PCWrite, PCWriteCond, Branch, ALU_operation). It also issues memory read/write strobes to the MIO bus. It sits directly upstream of the datapath, consuming its Inst and zero outputs.

Parameters:
none (ISA encodings live in the shared package)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
MIO_ready  in  1  memory/IO ready; 1 = access completes this cycle
Inst  in  32  IR contents from datapath; uses [31:26] op and [5:0] funct
zero  in  1  ALU zero flag from datapath
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
CPU_MIO  out  1  1 whenever MemRead or MemWrite is asserted
IorD  out  1  0 = PC address, 1 = ALUOut address
IRWrite  out  1  IR load enable
RegDst  out  2  00 rt, 01 rd, 10 $31
RegWrite  out  1  register file write
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 {imm,16'h0}, 11 PC
ALUSrcA  out  1  0 PC, 1 rs
ALUSrcB  out  2  00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
PCSource  out  2  00 ALU res, 01 ALUOut, 10 jump target, 11 rs
PCWrite  out  1  unconditional PC write
PCWriteCond  out  1  conditional PC write
Branch  out  1  1 = beq (take on zero), 0 = bne (take on !zero)
ALU_operation  out  3  ALU op code (package encoding)
state_out  out  4  current state, debug
illegal  out  1  one-cycle pulse on undecodable instruction

Behaviour:
- Reset: rst_n low forces state to IF asynchronously and every output to 0. The output forcing is combinational, so there are no strobes during reset. The first cycle after release is IF.
- Outputs: Moore decode of state and latched Inst. Unlisted outputs are 0 in every state. "add" means ALU_operation ADD.
- IF: MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=01, add, PCSource=00, PCWrite. Stay while MIO_ready=0; go to ID when MIO_ready=1.
- ID: ALUSrcA=0, ALUSrcB=11, add (ALUOut <= PC+4+off<<2). Next state by op:
  - lw/sw -> MA
  - R-type -> RX, except funct jr -> JR
  - beq/bne -> BR
  - j -> J
  - jal -> JAL
  - addi/slti/andi/ori/xori -> IX
  - lui -> LUI
  - anything else -> ILL
- MA: ALUSrcA=1, ALUSrcB=10, add. Next MRD (lw) or MWR (sw).
- MRD: MemRead, IorD=1, with the MA ALU controls held so ALUOut stays stable. Stay until MIO_ready=1, then go to LWB.
- LWB: RegDst=00, MemtoReg=01, RegWrite. Next IF.
- MWR: MemWrite, IorD=1, with the MA ALU controls held. Stay until MIO_ready=1, then go to IF.
- RX: ALUSrcA=1, ALUSrcB=00, op from funct:
  - add 100000 -> ADD
  - sub 100010 -> SUB
  - and 100100 -> AND
  - or 100101 -> OR
  - xor 100110 -> XOR
  - nor 100111 -> NOR
  - slt 101010 -> SLT
  - srl 000010 -> SRL
  - any other funct -> ILL
  Next RWB.
- RWB: RX ALU controls held, RegDst=01, MemtoReg=00, RegWrite. Next IF.
- IX: ALUSrcA=1, ALUSrcB=10, op per opcode (addi ADD, slti SLT, andi AND, ori OR, xori XOR). The immediate is always sign-extended (datapath fixed). Next IWB.
- IWB: IX ALU controls held, RegDst=00, MemtoReg=00, RegWrite. Next IF.
- LUI: RegDst=00, MemtoReg=10, RegWrite. Next IF.
- BR: ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond, PCSource=01, Branch=(op==beq).
- J: PCSource=10, PCWrite.
- JAL: PCSource=10, PCWrite, RegDst=10, MemtoReg=11, RegWrite. $31 receives PC_Current (already PC+4).
- JR: ALUSrcA=1, PCSource=11, PCWrite.
- Waiting in PC-writing states: BR, J, JAL and JR stay in place until MIO_ready=1, because the datapath gates the PC CE with MIO_ready; they go to IF on exit. In JAL, RegWrite stays asserted while waiting, which is idempotent.
- ILL: illegal=1 for one cycle, all other outputs 0. Next IF; PC already holds PC+4, so the instruction is skipped.
- CPI: R/I-type 4, lw 5, sw 4, branch/jump 3, lui 3 (each assuming MIO_ready=1).
- rst_n asserted mid-sequence (e.g. in MWR): MemWrite drops immediately and the FSM restarts at IF.

Decomposition:
- Package mc_isa_pkg holds:
  - opcode and funct localparams
  - 3-bit ALU_operation encodings: AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111
  - 4-bit state encodings: IF 0, ID 1, MA 2, MRD 3, LWB 4, MWR 5, RX 6, RWB 7, IX 8, IWB 9, LUI 10, BR 11, J 12, JAL 13, JR 14, ILL 15
- One sub-module, mc_alu_dec: combinational mapping of (op, funct) to ALU_operation plus an illegal-funct flag. It is reused by RX and IX.

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820) with MIO_ready=1: state sequence 0,1,6,7,0; RegWrite only in RWB; RegDst=01; ALU_operation=010; PCWrite only in IF.
- lw $2,4($1) (0x8C220004) with MIO_ready low 3 cycles in MRD: MRD held 4 cycles with MemRead=1, IorD=1, ALU controls constant; then LWB with MemtoReg=01, RegWrite=1.
- beq (0x10220003): with zero=1, BR shows PCWriteCond=1, Branch=1, PCSource=01, ALU_operation=110. Repeat with bne (0x14220003): Branch=0.
- jal 0x0C000010: IF, ID, JAL with RegDst=10, MemtoReg=11, RegWrite=1, PCSource=10, PCWrite=1; then IF.
- Illegal op 0xFC000000: IF, ID, ILL with illegal=1 for exactly one cycle; then IF.
- sw in MWR: drop rst_n mid-MWR; MemWrite goes to 0 the same cycle and all outputs read 0. After release, state_out=0 and MemRead=1.

Source files
------------

// File: rtl/mc_isa_pkg.sv
// Shared ISA encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU operation codes and FSM state encodings.
package mc_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_IF  = 4'd0,
        S_ID  = 4'd1,
        S_MA  = 4'd2,
        S_MRD = 4'd3,
        S_LWB = 4'd4,
        S_MWR = 4'd5,
        S_RX  = 4'd6,
        S_RWB = 4'd7,
        S_IX  = 4'd8,
        S_IWB = 4'd9,
        S_LUI = 4'd10,
        S_BR  = 4'd11,
        S_J   = 4'd12,
        S_JAL = 4'd13,
        S_JR  = 4'd14,
        S_ILL = 4'd15
    } state_t;

endpackage

// File: rtl/mc_alu_dec.sv
// Maps (op, funct) to an ALU operation for R-type and immediate ALU
// instructions; flags anything it cannot decode.
module mc_alu_dec
    import mc_isa_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_op,
    output logic       bad
);

    always_comb begin
        alu_op = ALU_ADD;
        bad    = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_op = ALU_ADD;
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_XOR:  alu_op = ALU_XOR;
                FN_NOR:  alu_op = ALU_NOR;
                FN_SLT:  alu_op = ALU_SLT;
                FN_SRL:  alu_op = ALU_SRL;
                default: bad    = 1'b1;
            endcase
        end else begin
            case (op)
                OP_ADDI: alu_op = ALU_ADD;
                OP_SLTI: alu_op = ALU_SLT;
                OP_ANDI: alu_op = ALU_AND;
                OP_ORI:  alu_op = ALU_OR;
                OP_XORI: alu_op = ALU_XOR;
                default: bad    = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Moore FSM sequencing the multi-cycle MIPS datapath and MIO bus strobes.
// Outputs are forced to zero combinationally while rst_n is low.
module mc_ctrl_unit
    import mc_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MIO_ready,
    input  logic [31:0] Inst,
    input  logic        zero,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        CPU_MIO,
    output logic        IorD,
    output logic        IRWrite,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic [1:0]  MemtoReg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSource,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        Branch,
    output logic [2:0]  ALU_operation,
    output logic [3:0]  state_out,
    output logic        illegal
);

    state_t     state_q, state_d;
    logic [5:0] op, funct;
    logic [2:0] dec_op;
    logic       dec_bad;

    assign op    = Inst[31:26];
    assign funct = Inst[5:0];

    mc_alu_dec u_alu_dec (
        .op     (op),
        .funct  (funct),
        .alu_op (dec_op),
        .bad    (dec_bad)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:  if (MIO_ready) state_d = S_ID;
            S_ID: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MA;
                    OP_RTYPE: begin
                        if (funct == FN_JR) state_d = S_JR;
                        else if (dec_bad)   state_d = S_ILL;
                        else                state_d = S_RX;
                    end
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_J:           state_d = S_J;
                    OP_JAL:         state_d = S_JAL;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IX;
                    OP_LUI:         state_d = S_LUI;
                    default:        state_d = S_ILL;
                endcase
            end
            S_MA:  state_d = (op == OP_SW) ? S_MWR : S_MRD;
            S_MRD: if (MIO_ready) state_d = S_LWB;
            S_MWR: if (MIO_ready) state_d = S_IF;
            S_RX:  state_d = S_RWB;
            S_IX:  state_d = S_IWB;
            // PC-writing states wait because the datapath gates PC CE with MIO_ready.
            S_BR, S_J, S_JAL, S_JR: if (MIO_ready) state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 2'b00;
        RegWrite      = 1'b0;
        MemtoReg      = 2'b00;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSource      = 2'b00;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        ALU_operation = ALU_AND;
        illegal       = 1'b0;
        state_out     = 4'd0;
        if (rst_n) begin
            state_out = state_q;
            case (state_q)
                S_IF: begin
                    MemRead = 1'b1; IRWrite = 1'b1; ALUSrcB = 2'b01;
                    ALU_operation = ALU_ADD; PCWrite = 1'b1;
                end
                S_ID: begin
                    ALUSrcB = 2'b11; ALU_operation = ALU_ADD;
                end
                S_MA, S_MRD, S_MWR: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = ALU_ADD;
                    MemRead  = (state_q == S_MRD);
                    MemWrite = (state_q == S_MWR);
                    IorD     = (state_q != S_MA);
                end
                S_LWB: begin
                    MemtoReg = 2'b01; RegWrite = 1'b1;
                end
                S_RX, S_RWB: begin
                    ALUSrcA = 1'b1; ALU_operation = dec_op;
                    if (state_q == S_RWB) begin
                        RegDst = 2'b01; RegWrite = 1'b1;
                    end
                end
                S_IX, S_IWB: begin
                    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALU_operation = dec_op;
                    RegWrite = (state_q == S_IWB);
                end
                S_LUI: begin
                    MemtoReg = 2'b10; RegWrite = 1'b1;
                end
                S_BR: begin
                    ALUSrcA = 1'b1; ALU_operation = ALU_SUB; PCWriteCond = 1'b1;
                    PCSource = 2'b01; Branch = (op == OP_BEQ);
                end
                S_J: begin
                    PCSource = 2'b10; PCWrite = 1'b1;
                end
                S_JAL: begin
                    PCSource = 2'b10; PCWrite = 1'b1; RegDst = 2'b10;
                    MemtoReg = 2'b11; RegWrite = 1'b1;
                end
                S_JR: begin
                    ALUSrcA = 1'b1; PCSource = 2'b11; PCWrite = 1'b1;
                end
                default: illegal = 1'b1;
            endcase
        end
        CPU_MIO = MemRead | MemWrite;
    end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Bench for mc_ctrl_unit: table of per-cycle steps checked through a
// scoreboard queue, plus a hand-written reset-during-store sequence.
module tb_mc_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MIO_ready;
    logic [31:0] Inst;
    logic        zero;
    logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic        ALUSrcA, PCWrite, PCWriteCond, Branch, illegal;
    logic [2:0]  ALU_operation;
    logic [3:0]  state_out;

    always #5 clk = ~clk;

    mc_ctrl_unit dut (
        .clk(clk), .rst_n(rst_n), .MIO_ready(MIO_ready), .Inst(Inst), .zero(zero),
        .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD),
        .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .Branch(Branch), .ALU_operation(ALU_operation),
        .state_out(state_out), .illegal(illegal)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mr, mw, mio, iord, irw;
        logic [1:0] rdst;
        logic       rw;
        logic [1:0] m2r;
        logic       srca;
        logic [1:0] srcb, pcs;
        logic       pcw, pcwc, br;
        logic [2:0] aluop;
        logic       ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic        z;
        logic        rdy;
        exp_t        e;
    } vec_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [3:0] st, input logic mr, input logic mw,
                                input logic iord, input logic irw, input logic [1:0] rdst,
                                input logic rw, input logic [1:0] m2r, input logic srca,
                                input logic [1:0] srcb, input logic [1:0] pcs, input logic pcw,
                                input logic pcwc, input logic br, input logic [2:0] aluop,
                                input logic ill);
        exp_t e;
        e.st = st; e.mr = mr; e.mw = mw; e.mio = mr | mw; e.iord = iord; e.irw = irw;
        e.rdst = rdst; e.rw = rw; e.m2r = m2r; e.srca = srca; e.srcb = srcb; e.pcs = pcs;
        e.pcw = pcw; e.pcwc = pcwc; e.br = br; e.aluop = aluop; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.st = state_out; a.mr = MemRead; a.mw = MemWrite; a.mio = CPU_MIO; a.iord = IorD;
        a.irw = IRWrite; a.rdst = RegDst; a.rw = RegWrite; a.m2r = MemtoReg; a.srca = ALUSrcA;
        a.srcb = ALUSrcB; a.pcs = PCSource; a.pcw = PCWrite; a.pcwc = PCWriteCond;
        a.br = Branch; a.aluop = ALU_operation; a.ill = illegal;
        return a;
    endfunction

    task automatic check_now(input string name);
        exp_t ex, got;
        ex  = sb.pop_front();
        got = sample();
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL %s got st=%0d bits=%h exp st=%0d bits=%h",
                     name, got.st, got, ex.st, ex);
        end
    endtask

    task automatic step(input string name, input logic [31:0] inst, input logic z,
                        input logic rdy, input exp_t e);
        @(negedge clk);
        Inst = inst; zero = z; MIO_ready = rdy;
        sb.push_back(e);
        #1;
        check_now(name);
    endtask

    task automatic add(input string name, input logic [31:0] inst, input logic z,
                       input logic rdy, input exp_t e);
        vec_t v;
        v.name = name; v.inst = inst; v.z = z; v.rdy = rdy; v.e = e;
        tbl.push_back(v);
    endtask

    localparam logic [31:0] I_ADD = 32'h0022_1820;
    localparam logic [31:0] I_SUB = 32'h0022_1822;
    localparam logic [31:0] I_LW  = 32'h8C22_0004;
    localparam logic [31:0] I_SW  = 32'hAC22_0004;
    localparam logic [31:0] I_BEQ = 32'h1022_0003;
    localparam logic [31:0] I_BNE = 32'h1422_0003;
    localparam logic [31:0] I_JAL = 32'h0C00_0010;
    localparam logic [31:0] I_J   = 32'h0800_0010;
    localparam logic [31:0] I_ILL = 32'hFC00_0000;
    localparam logic [31:0] I_ORI = 32'h3441_0005;
    localparam logic [31:0] I_LUI = 32'h3C01_1234;

    initial begin
        exp_t e_zero, e_if, e_id, e_ma, e_mrd, e_lwb, e_mwr, e_rx_add, e_rwb_add;
        exp_t e_rx_sub, e_rwb_sub, e_ix, e_iwb, e_lui, e_beq, e_bne, e_j, e_jal, e_ill;

        //                 st    mr mw io ir rdst  rw m2r   sa srcb  pcs   pw pc br alu     il
        e_zero    = mk(4'd0,  0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 0);
        e_if      = mk(4'd0,  1, 0, 0, 1, 2'b00, 0, 2'b00, 0, 2'b01, 2'b00, 1, 0, 0, 3'b010, 0);
        e_id      = mk(4'd1,  0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b11, 2'b00, 0, 0, 0, 3'b010, 0);
        e_ma      = mk(4'd2,  0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 3'b010, 0);
        e_mrd     = mk(4'd3,  1, 0, 1, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 3'b010, 0);
        e_lwb     = mk(4'd4,  0, 0, 0, 0, 2'b00, 1, 2'b01, 0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 0);
        e_mwr     = mk(4'd5,  0, 1, 1, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 3'b010, 0);
        e_rx_add  = mk(4'd6,  0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 3'b010, 0);
        e_rwb_add = mk(4'd7,  0, 0, 0, 0, 2'b01, 1, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 3'b010, 0);
        e_rx_sub  = mk(4'd6,  0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 3'b110, 0);
        e_rwb_sub = mk(4'd7,  0, 0, 0, 0, 2'b01, 1, 2'b00, 1, 2'b00, 2'b00, 0, 0, 0, 3'b110, 0);
        e_ix      = mk(4'd8,  0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 3'b001, 0);
        e_iwb     = mk(4'd9,  0, 0, 0, 0, 2'b00, 1, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 3'b001, 0);
        e_lui     = mk(4'd10, 0, 0, 0, 0, 2'b00, 1, 2'b10, 0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 0);
        e_beq     = mk(4'd11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 2'b01, 0, 1, 1, 3'b110, 0);
        e_bne     = mk(4'd11, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1, 2'b00, 2'b01, 0, 1, 0, 3'b110, 0);
        e_j       = mk(4'd12, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b10, 1, 0, 0, 3'b000, 0);
        e_jal     = mk(4'd13, 0, 0, 0, 0, 2'b10, 1, 2'b11, 0, 2'b00, 2'b10, 1, 0, 0, 3'b000, 0);
        e_ill     = mk(4'd15, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 3'b000, 1);

        add("add_if_wait", I_ADD, 0, 0, e_if);
        add("add_if",      I_ADD, 0, 1, e_if);
        add("add_id",      I_ADD, 0, 1, e_id);
        add("add_rx",      I_ADD, 0, 1, e_rx_add);
        add("add_rwb",     I_ADD, 0, 1, e_rwb_add);
        add("lw_if",       I_LW,  0, 1, e_if);
        add("lw_id",       I_LW,  0, 1, e_id);
        add("lw_ma",       I_LW,  0, 1, e_ma);
        add("lw_mrd0",     I_LW,  0, 0, e_mrd);
        add("lw_mrd1",     I_LW,  0, 0, e_mrd);
        add("lw_mrd2",     I_LW,  0, 0, e_mrd);
        add("lw_mrd3",     I_LW,  0, 1, e_mrd);
        add("lw_lwb",      I_LW,  0, 1, e_lwb);
        add("beq_if",      I_BEQ, 1, 1, e_if);
        add("beq_id",      I_BEQ, 1, 1, e_id);
        add("beq_br",      I_BEQ, 1, 1, e_beq);
        add("bne_if",      I_BNE, 1, 1, e_if);
        add("bne_id",      I_BNE, 1, 1, e_id);
        add("bne_br",      I_BNE, 1, 1, e_bne);
        add("jal_if",      I_JAL, 0, 1, e_if);
        add("jal_id",      I_JAL, 0, 1, e_id);
        add("jal_jal",     I_JAL, 0, 1, e_jal);
        add("ill_if",      I_ILL, 0, 1, e_if);
        add("ill_id",      I_ILL, 0, 1, e_id);
        add("ill_ill",     I_ILL, 0, 1, e_ill);
        add("sub_if",      I_SUB, 0, 1, e_if);
        add("sub_id",      I_SUB, 0, 1, e_id);
        add("sub_rx",      I_SUB, 0, 1, e_rx_sub);
        add("sub_rwb",     I_SUB, 0, 1, e_rwb_sub);
        add("ori_if",      I_ORI, 0, 1, e_if);
        add("ori_id",      I_ORI, 0, 1, e_id);
        add("ori_ix",      I_ORI, 0, 1, e_ix);
        add("ori_iwb",     I_ORI, 0, 1, e_iwb);
        add("lui_if",      I_LUI, 0, 1, e_if);
        add("lui_id",      I_LUI, 0, 1, e_id);
        add("lui_lui",     I_LUI, 0, 1, e_lui);
        add("j_if",        I_J,   0, 1, e_if);
        add("j_id",        I_J,   0, 1, e_id);
        add("j_wait",      I_J,   0, 0, e_j);
        add("j_j",         I_J,   0, 1, e_j);
        add("sw_if",       I_SW,  0, 1, e_if);
        add("sw_id",       I_SW,  0, 1, e_id);
        add("sw_ma",       I_SW,  0, 1, e_ma);
        add("sw_mwr",      I_SW,  0, 0, e_mwr);

        rst_n = 1'b0; MIO_ready = 1'b0; Inst = 32'h0; zero = 1'b0;
        repeat (2) @(negedge clk);
        sb.push_back(e_zero);
        #1;
        check_now("reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i].name, tbl[i].inst, tbl[i].z, tbl[i].rdy, tbl[i].e);

        // Store is parked in MWR; pull reset mid-cycle and expect strobes to drop at once.
        #2;
        rst_n = 1'b0;
        sb.push_back(e_zero);
        #1;
        check_now("sw_reset_mid_mwr");
        @(posedge clk);
        @(negedge clk);
        MIO_ready = 1'b0;
        rst_n = 1'b1;
        step("after_reset_if", I_SW, 0, 0, e_if);
        step("after_reset_hold", I_SW, 0, 1, e_if);
        step("after_reset_id", I_SW, 0, 1, e_id);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
